// File: rtl/primitive_sequencer.sv
// primitive_sequencer: gathers vertex/colour commands into triangles for the GPU rasteriser.
// Optional feature macro: STRIP_MODE_EN enables triangle strips; without it every primitive is a list.
module primitive_sequencer #(
  parameter int VTX_W = 30,
  parameter int GSR_W = 32
) (
  input  logic             I_CLOCK,
  input  logic             I_RESET_N,
  input  logic             I_LOCK,
  input  logic             I_SetVertex,
  input  logic [VTX_W-1:0] I_Vertex,
  input  logic             I_SetColor,
  input  logic [GSR_W-1:0] I_Color,
  input  logic             I_BeginPrim,
  input  logic             I_PrimType,
  input  logic             I_EndPrim,
  input  logic             I_GPUStallSignal,
  output logic             O_Stall,
  output logic             O_TriValid,
  output logic [VTX_W-1:0] O_VertexV1,
  output logic [VTX_W-1:0] O_VertexV2,
  output logic [VTX_W-1:0] O_VertexV3,
  output logic [GSR_W-1:0] O_GSRValue,
  output logic             O_Busy,
  output logic             O_Error
);

  typedef enum logic {IDLE = 1'b0, PRIM = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [1:0]       vcount_q, vcount_d;
  logic [GSR_W-1:0] color_q, color_d;
  logic [GSR_W-1:0] gsr_q, gsr_d;
  logic [VTX_W-1:0] v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic             tri_valid_q, tri_valid_d;
  logic             error_q, error_d;
  logic             stall;
  logic             accept;

`ifdef STRIP_MODE_EN
  logic strip_q, strip_d;
`else
  logic unused_prim_type;
  assign unused_prim_type = I_PrimType;
`endif

  assign stall  = tri_valid_q & I_GPUStallSignal;
  assign accept = I_LOCK & ~stall;

  // Commands on one edge resolve in the order Begin, Color, Vertex, End,
  // so each step below sees the effect of the ones before it.
  always_comb begin
    state_d     = state_q;
    vcount_d    = vcount_q;
    color_d     = color_q;
    gsr_d       = gsr_q;
    v1_d        = v1_q;
    v2_d        = v2_q;
    v3_d        = v3_q;
    error_d     = error_q;
    tri_valid_d = tri_valid_q & I_GPUStallSignal;
`ifdef STRIP_MODE_EN
    strip_d     = strip_q;
`endif
    if (accept) begin
      if (I_BeginPrim) begin
        if (state_q == PRIM) error_d = 1'b1;
        state_d  = PRIM;
        vcount_d = 2'd0;
`ifdef STRIP_MODE_EN
        strip_d  = I_PrimType;
`endif
      end
      if (I_SetColor) color_d = I_Color;
      if (I_SetVertex) begin
        if (state_d == PRIM) begin
          v1_d = v2_q;
          v2_d = v3_q;
          v3_d = I_Vertex;
`ifdef STRIP_MODE_EN
          if (vcount_d != 2'd3) vcount_d = vcount_d + 2'd1;
`else
          vcount_d = vcount_d + 2'd1;
`endif
          if (vcount_d == 2'd3) begin
            tri_valid_d = 1'b1;
            gsr_d       = color_d;
`ifdef STRIP_MODE_EN
            vcount_d    = strip_d ? 2'd3 : 2'd0;
`else
            vcount_d    = 2'd0;
`endif
          end
        end else begin
          error_d = 1'b1;
        end
      end
      if (I_EndPrim) begin
        if (state_d == PRIM) begin
          state_d = IDLE;
`ifdef STRIP_MODE_EN
          if (strip_d ? (vcount_d != 2'd3) : (vcount_d == 2'd1 || vcount_d == 2'd2))
            error_d = 1'b1;
`else
          if (vcount_d == 2'd1 || vcount_d == 2'd2) error_d = 1'b1;
`endif
        end else begin
          error_d = 1'b1;
        end
      end
    end
  end

  always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      state_q     <= IDLE;
      vcount_q    <= 2'd0;
      color_q     <= '0;
      gsr_q       <= '0;
      v1_q        <= '0;
      v2_q        <= '0;
      v3_q        <= '0;
      tri_valid_q <= 1'b0;
      error_q     <= 1'b0;
`ifdef STRIP_MODE_EN
      strip_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      vcount_q    <= vcount_d;
      color_q     <= color_d;
      gsr_q       <= gsr_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      v3_q        <= v3_d;
      tri_valid_q <= tri_valid_d;
      error_q     <= error_d;
`ifdef STRIP_MODE_EN
      strip_q     <= strip_d;
`endif
    end
  end

  assign O_Stall    = stall;
  assign O_TriValid = tri_valid_q;
  assign O_VertexV1 = v1_q;
  assign O_VertexV2 = v2_q;
  assign O_VertexV3 = v3_q;
  assign O_GSRValue = gsr_q;
  assign O_Busy     = (state_q == PRIM);
  assign O_Error    = error_q;

endmodule

// File: tb/tb_primitive_sequencer.sv
// Self-checking bench for primitive_sequencer: scripted scenarios with a triangle scoreboard.
module tb_primitive_sequencer;
  localparam int VTX_W = 30;
  localparam int GSR_W = 32;
`ifdef STRIP_MODE_EN
  localparam bit STRIP = 1'b1;
`else
  localparam bit STRIP = 1'b0;
`endif

  typedef struct packed {
    logic [VTX_W-1:0] v1;
    logic [VTX_W-1:0] v2;
    logic [VTX_W-1:0] v3;
    logic [GSR_W-1:0] gsr;
  } tri_t;

  logic             I_CLOCK, I_RESET_N, I_LOCK;
  logic             I_SetVertex, I_SetColor, I_BeginPrim, I_PrimType, I_EndPrim;
  logic             I_GPUStallSignal;
  logic [VTX_W-1:0] I_Vertex;
  logic [GSR_W-1:0] I_Color;
  logic             O_Stall, O_TriValid, O_Busy, O_Error;
  logic [VTX_W-1:0] O_VertexV1, O_VertexV2, O_VertexV3;
  logic [GSR_W-1:0] O_GSRValue;

  tri_t sb[$];
  tri_t exp_t;
  int   n_cmp;
  int   n_bad;

  primitive_sequencer #(.VTX_W(VTX_W), .GSR_W(GSR_W)) dut (
    .I_CLOCK(I_CLOCK), .I_RESET_N(I_RESET_N), .I_LOCK(I_LOCK),
    .I_SetVertex(I_SetVertex), .I_Vertex(I_Vertex),
    .I_SetColor(I_SetColor), .I_Color(I_Color),
    .I_BeginPrim(I_BeginPrim), .I_PrimType(I_PrimType), .I_EndPrim(I_EndPrim),
    .I_GPUStallSignal(I_GPUStallSignal),
    .O_Stall(O_Stall), .O_TriValid(O_TriValid),
    .O_VertexV1(O_VertexV1), .O_VertexV2(O_VertexV2), .O_VertexV3(O_VertexV3),
    .O_GSRValue(O_GSRValue), .O_Busy(O_Busy), .O_Error(O_Error)
  );

  initial begin
    I_CLOCK = 1'b0;
    forever #5 I_CLOCK = ~I_CLOCK;
  end

  task automatic tick();
    @(negedge I_CLOCK);
    #1;
  endtask

  task automatic idle_cmds();
    I_SetVertex = 1'b0;
    I_SetColor  = 1'b0;
    I_BeginPrim = 1'b0;
    I_EndPrim   = 1'b0;
  endtask

  task automatic test_reset();
    I_RESET_N = 1'b1; I_LOCK = 1'b1; I_GPUStallSignal = 1'b0; I_PrimType = 1'b0;
    I_Vertex = '0; I_Color = '0;
    idle_cmds();
    #2 I_RESET_N = 1'b0;
    #1;
    n_cmp++;
    if ({O_TriValid, O_Stall, O_Busy, O_Error} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 0000", {O_TriValid, O_Stall, O_Busy, O_Error});
    end
    n_cmp++;
    if ({O_VertexV1, O_VertexV2, O_VertexV3, O_GSRValue} !== '0) begin
      n_bad++; $display("FAIL reset_data: got %h/%h/%h/%h want all 0", O_VertexV1, O_VertexV2, O_VertexV3, O_GSRValue);
    end
    #3 I_RESET_N = 1'b1;
    tick();
    n_cmp++;
    if (O_Busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle: busy got %b want 0", O_Busy); end
  endtask

  task automatic test_list();
    idle_cmds(); I_BeginPrim = 1'b1; I_PrimType = 1'b0;
    tick();
    idle_cmds();
    n_cmp++;
    if (O_Busy !== 1'b1) begin n_bad++; $display("FAIL list_busy: got %b want 1", O_Busy); end
    for (int i = 1; i <= 6; i++) begin
      I_SetVertex = 1'b1; I_Vertex = VTX_W'(i);
      if (i % 3 == 0) sb.push_back('{v1: VTX_W'(i-2), v2: VTX_W'(i-1), v3: VTX_W'(i), gsr: '0});
      tick();
      n_cmp++;
      if (O_TriValid !== (i % 3 == 0)) begin
        n_bad++; $display("FAIL list_valid[%0d]: got %b want %b", i, O_TriValid, (i % 3 == 0));
      end
      if (O_TriValid) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++; $display("FAIL list_tri: got unexpected %h/%h/%h want none", O_VertexV1, O_VertexV2, O_VertexV3);
        end else begin
          exp_t = sb.pop_front();
          if ({O_VertexV1, O_VertexV2, O_VertexV3, O_GSRValue} !== exp_t) begin
            n_bad++; $display("FAIL list_tri: got %h/%h/%h/%h want %h/%h/%h/%h", O_VertexV1, O_VertexV2, O_VertexV3, O_GSRValue, exp_t.v1, exp_t.v2, exp_t.v3, exp_t.gsr);
          end
        end
      end
    end
    idle_cmds(); I_EndPrim = 1'b1;
    tick();
    idle_cmds();
    n_cmp++;
    if ({O_TriValid, O_Busy, O_Error} !== 3'b000) begin
      n_bad++; $display("FAIL list_end: valid/busy/err got %b want 000", {O_TriValid, O_Busy, O_Error});
    end
  endtask

  task automatic test_strip();
    logic want;
    idle_cmds(); I_BeginPrim = 1'b1; I_PrimType = 1'b1;
    tick();
    idle_cmds();
    for (int k = 0; k < 6; k++) begin
      want = STRIP ? (k >= 2) : (k % 3 == 2);
      I_SetVertex = 1'b1; I_Vertex = VTX_W'(32'hA + k);
      if (want) sb.push_back('{v1: VTX_W'(32'hA + k - 2), v2: VTX_W'(32'hA + k - 1), v3: VTX_W'(32'hA + k), gsr: '0});
      tick();
      n_cmp++;
      if (O_TriValid !== want) begin
        n_bad++; $display("FAIL strip_valid[%0d]: got %b want %b", k, O_TriValid, want);
      end
      if (O_TriValid) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++; $display("FAIL strip_tri: got unexpected %h/%h/%h want none", O_VertexV1, O_VertexV2, O_VertexV3);
        end else begin
          exp_t = sb.pop_front();
          if ({O_VertexV1, O_VertexV2, O_VertexV3, O_GSRValue} !== exp_t) begin
            n_bad++; $display("FAIL strip_tri: got %h/%h/%h/%h want %h/%h/%h/%h", O_VertexV1, O_VertexV2, O_VertexV3, O_GSRValue, exp_t.v1, exp_t.v2, exp_t.v3, exp_t.gsr);
          end
        end
      end
    end
    idle_cmds(); I_EndPrim = 1'b1; I_PrimType = 1'b0;
    tick();
    idle_cmds();
    n_cmp++;
    if ({O_TriValid, O_Busy, O_Error} !== 3'b000) begin
      n_bad++; $display("FAIL strip_end: valid/busy/err got %b want 000", {O_TriValid, O_Busy, O_Error});
    end
  endtask

  task automatic test_stall();
    idle_cmds(); I_BeginPrim = 1'b1;
    tick();
    idle_cmds();
    for (int i = 1; i <= 6; i++) begin
      I_SetVertex = 1'b1; I_Vertex = VTX_W'(i);
      if (i % 3 == 0) sb.push_back('{v1: VTX_W'(i-2), v2: VTX_W'(i-1), v3: VTX_W'(i), gsr: '0});
      tick();
      if (O_TriValid) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++; $display("FAIL stall_tri: got unexpected %h/%h/%h want none", O_VertexV1, O_VertexV2, O_VertexV3);
        end else begin
          exp_t = sb.pop_front();
          if ({O_VertexV1, O_VertexV2, O_VertexV3, O_GSRValue} !== exp_t) begin
            n_bad++; $display("FAIL stall_tri: got %h/%h/%h/%h want %h/%h/%h/%h", O_VertexV1, O_VertexV2, O_VertexV3, O_GSRValue, exp_t.v1, exp_t.v2, exp_t.v3, exp_t.gsr);
          end
        end
      end
      if (i == 3) begin
        // Hold the GPU off for four edges while vertex 4 waits upstream.
        I_GPUStallSignal = 1'b1; I_Vertex = VTX_W'(4);
        for (int c = 0; c < 4; c++) begin
          #1;
          n_cmp++;
          if (O_Stall !== 1'b1) begin n_bad++; $display("FAIL stall_flag[%0d]: got %b want 1", c, O_Stall); end
          tick();
          n_cmp++;
          if ({O_TriValid, O_VertexV1, O_VertexV2, O_VertexV3} !== {1'b1, VTX_W'(1), VTX_W'(2), VTX_W'(3)}) begin
            n_bad++; $display("FAIL stall_hold[%0d]: got %b %h/%h/%h want 1 1/2/3", c, O_TriValid, O_VertexV1, O_VertexV2, O_VertexV3);
          end
        end
        I_GPUStallSignal = 1'b0;
        tick();
        n_cmp++;
        if ({O_TriValid, O_Stall, O_VertexV3} !== {2'b00, VTX_W'(4)}) begin
          n_bad++; $display("FAIL stall_release: got valid=%b stall=%b v3=%h want 0 0 4", O_TriValid, O_Stall, O_VertexV3);
        end
        i = 4;
      end
    end
    idle_cmds(); I_EndPrim = 1'b1;
    tick();
    idle_cmds();
    n_cmp++;
    if ({O_TriValid, O_Busy, O_Error} !== 3'b000) begin
      n_bad++; $display("FAIL stall_end: valid/busy/err got %b want 000", {O_TriValid, O_Busy, O_Error});
    end
  endtask

  task automatic test_color();
    idle_cmds(); I_BeginPrim = 1'b1;
    tick();
    idle_cmds();
    for (int i = 0; i < 6; i++) begin
      I_SetVertex = 1'b1; I_Vertex = VTX_W'(32'h11 + i);
      I_SetColor = (i == 2) || (i == 3);
      I_Color = (i == 2) ? 32'h0000FF00 : 32'h00FF0000;
      if (i == 2) sb.push_back('{v1: VTX_W'(32'h11), v2: VTX_W'(32'h12), v3: VTX_W'(32'h13), gsr: 32'h0000FF00});
      if (i == 5) sb.push_back('{v1: VTX_W'(32'h14), v2: VTX_W'(32'h15), v3: VTX_W'(32'h16), gsr: 32'h00FF0000});
      tick();
      if (O_TriValid) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++; $display("FAIL color_tri: got unexpected %h/%h/%h want none", O_VertexV1, O_VertexV2, O_VertexV3);
        end else begin
          exp_t = sb.pop_front();
          if ({O_VertexV1, O_VertexV2, O_VertexV3, O_GSRValue} !== exp_t) begin
            n_bad++; $display("FAIL color_tri: got %h/%h/%h/%h want %h/%h/%h/%h", O_VertexV1, O_VertexV2, O_VertexV3, O_GSRValue, exp_t.v1, exp_t.v2, exp_t.v3, exp_t.gsr);
          end
        end
      end
    end
    idle_cmds(); I_EndPrim = 1'b1;
    tick();
    idle_cmds();
  endtask

  task automatic test_lock();
    idle_cmds(); I_LOCK = 1'b0; I_BeginPrim = 1'b1;
    tick();
    n_cmp++;
    if (O_Busy !== 1'b0) begin n_bad++; $display("FAIL lock_begin: busy got %b want 0", O_Busy); end
    I_LOCK = 1'b1;
    tick();
    idle_cmds();
    for (int i = 1; i <= 3; i++) begin
      I_SetVertex = 1'b1; I_Vertex = VTX_W'(32'h30 + i);
      if (i == 3) sb.push_back('{v1: VTX_W'(32'h31), v2: VTX_W'(32'h32), v3: VTX_W'(32'h33), gsr: 32'h00FF0000});
      tick();
      if (O_TriValid) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++; $display("FAIL lock_tri: got unexpected %h/%h/%h want none", O_VertexV1, O_VertexV2, O_VertexV3);
        end else begin
          exp_t = sb.pop_front();
          if ({O_VertexV1, O_VertexV2, O_VertexV3, O_GSRValue} !== exp_t) begin
            n_bad++; $display("FAIL lock_tri: got %h/%h/%h/%h want %h/%h/%h/%h", O_VertexV1, O_VertexV2, O_VertexV3, O_GSRValue, exp_t.v1, exp_t.v2, exp_t.v3, exp_t.gsr);
          end
        end
      end
    end
    I_LOCK = 1'b0; I_Vertex = VTX_W'(32'h39);
    tick();
    n_cmp++;
    if ({O_TriValid, O_VertexV3} !== {1'b0, VTX_W'(32'h33)}) begin
      n_bad++; $display("FAIL lock_drain: got valid=%b v3=%h want 0 33", O_TriValid, O_VertexV3);
    end
    idle_cmds(); I_LOCK = 1'b1; I_EndPrim = 1'b1;
    tick();
    idle_cmds();
    n_cmp++;
    if ({O_Busy, O_Error} !== 2'b00) begin n_bad++; $display("FAIL lock_end: busy/err got %b want 00", {O_Busy, O_Error}); end
  endtask

  task automatic test_errors();
    idle_cmds(); I_SetVertex = 1'b1; I_Vertex = VTX_W'(7);
    tick();
    idle_cmds();
    n_cmp++;
    if ({O_Error, O_Busy, O_TriValid, O_VertexV3} !== {3'b100, VTX_W'(32'h33)}) begin
      n_bad++; $display("FAIL err_idle_vertex: got err=%b busy=%b valid=%b v3=%h want 1 0 0 33", O_Error, O_Busy, O_TriValid, O_VertexV3);
    end
    I_RESET_N = 1'b0;
    #1;
    n_cmp++;
    if (O_Error !== 1'b0) begin n_bad++; $display("FAIL err_clear: got %b want 0", O_Error); end
    I_RESET_N = 1'b1;
    tick();
    I_BeginPrim = 1'b1;
    tick();
    idle_cmds(); I_SetVertex = 1'b1; I_Vertex = VTX_W'(8);
    tick();
    idle_cmds(); I_EndPrim = 1'b1;
    tick();
    idle_cmds();
    n_cmp++;
    if ({O_Error, O_Busy, O_TriValid} !== 3'b100) begin
      n_bad++; $display("FAIL err_short_prim: err/busy/valid got %b want 100", {O_Error, O_Busy, O_TriValid});
    end
  endtask

  task automatic test_reset_mid();
    I_RESET_N = 1'b0;
    #1 I_RESET_N = 1'b1;
    tick();
    I_BeginPrim = 1'b1;
    tick();
    idle_cmds();
    for (int i = 1; i <= 3; i++) begin
      I_SetVertex = 1'b1; I_Vertex = VTX_W'(32'h20 + i);
      if (i == 3) I_GPUStallSignal = 1'b1;
      tick();
    end
    idle_cmds();
    n_cmp++;
    if ({O_TriValid, O_Stall} !== 2'b11) begin n_bad++; $display("FAIL rstmid_pending: valid/stall got %b want 11", {O_TriValid, O_Stall}); end
    #2 I_RESET_N = 1'b0;
    #1;
    n_cmp++;
    if ({O_TriValid, O_Stall, O_Busy, O_Error, O_VertexV1, O_VertexV2, O_VertexV3, O_GSRValue} !== '0) begin
      n_bad++; $display("FAIL rstmid_async: got %b%b%b%b %h/%h/%h/%h want all 0", O_TriValid, O_Stall, O_Busy, O_Error, O_VertexV1, O_VertexV2, O_VertexV3, O_GSRValue);
    end
    I_RESET_N = 1'b1; I_GPUStallSignal = 1'b0;
    tick();
    I_BeginPrim = 1'b1;
    tick();
    idle_cmds();
    for (int i = 4; i <= 6; i++) begin
      I_SetVertex = 1'b1; I_Vertex = VTX_W'(32'h20 + i);
      if (i == 6) sb.push_back('{v1: VTX_W'(32'h24), v2: VTX_W'(32'h25), v3: VTX_W'(32'h26), gsr: '0});
      tick();
      if (O_TriValid) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++; $display("FAIL rstmid_tri: got unexpected %h/%h/%h want none", O_VertexV1, O_VertexV2, O_VertexV3);
        end else begin
          exp_t = sb.pop_front();
          if ({O_VertexV1, O_VertexV2, O_VertexV3, O_GSRValue} !== exp_t) begin
            n_bad++; $display("FAIL rstmid_tri: got %h/%h/%h/%h want %h/%h/%h/%h", O_VertexV1, O_VertexV2, O_VertexV3, O_GSRValue, exp_t.v1, exp_t.v2, exp_t.v3, exp_t.gsr);
          end
        end
      end
    end
    idle_cmds(); I_EndPrim = 1'b1;
    tick();
    idle_cmds();
    n_cmp++;
    if ({O_TriValid, O_Busy, O_Error} !== 3'b000) begin
      n_bad++; $display("FAIL rstmid_end: valid/busy/err got %b want 000", {O_TriValid, O_Busy, O_Error});
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_list();
    test_strip();
    test_stall();
    test_color();
    test_lock();
    test_errors();
    test_reset_mid();
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL scoreboard_leftover: got %0d triangles outstanding want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
